uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-002 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1 or 2.
REQ-004 SHALL have parameter BAUD_DIV, default 104: clk cycles per bit, legal >= 2 (12 MHz / 115200).
REQ-005 SHALL have parameter DEPTH, default 4: transmit FIFO entries, power of two, >= 2.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  write strobe, pushes data when ready=1.
REQ-009 SHALL have port data  input  DATA_BITS  byte to queue.
REQ-010 SHALL have port tx  output  1  registered serial line, idle high.
REQ-011 SHALL have port ready  output  1  FIFO not full.
REQ-012 SHALL have port busy  output  1  frame in progress or FIFO not empty.
REQ-013 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Push SHALL occur on a cycle with start=1 and ready=1; start with ready=0 SHALL be ignored, no state change.
REQ-015 FSM states SHALL be IDLE, LOAD, START, DATA, PAR, STOP.
REQ-016 IDLE -> LOAD when FIFO non-empty; LOAD lasts exactly 1 cycle, pops the head entry into the shift register and clears baud and bit counters.
REQ-017 START, each DATA bit, PAR and each stop bit SHALL last exactly BAUD_DIV cycles; data sent LSB first.
REQ-018 PAR state SHALL be skipped when PARITY=0; parity bit = XOR of data bits (even) or its inverse (odd).
REQ-019 STOP SHALL last STOP_BITS*BAUD_DIV cycles, then go to LOAD if FIFO non-empty, else IDLE (inter-frame gap: one LOAD cycle, line high).
REQ-020 tx SHALL be registered: line value for a state appears one cycle after entering it; push at cycle n into empty idle block gives LOAD at n+1, tx=0 over cycles n+2..n+1+BAUD_DIV.
REQ-021 Simultaneous push and pop SHALL leave level unchanged and both operations take effect; push on full with pop in same cycle SHALL be ignored (ready reflects registered full).
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.
REQ-023 busy SHALL be 0 only when state=IDLE and level=0.
REQ-024 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV+1 cycles including LOAD.

Reset
REQ-025 rstn=0 SHALL immediately force tx=1, state=IDLE, level=0, FIFO pointers 0, busy=0, ready=1, counters 0.
REQ-026 Reset mid-frame SHALL abort the frame and discard all queued entries; no further bits after rstn release until a new push.

Structure
REQ-027 State encoding and PARITY mode constants SHALL live in the shared package/header used with baud definitions (baudgen.vh).
REQ-028 Baud timing SHALL be a sub-module uart_baud_tick (enable, clear, one-cycle tick every BAUD_DIV cycles); FIFO is inline.

Verification
REQ-029 8N1, BAUD_DIV=4, push 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 each 4 cycles, then high; busy drops after stop.
REQ-030 8E1, push 0xA7 (5 ones) -> parity bit 1; 8O1 same data -> parity bit 0.
REQ-031 7N2, push 0x41 -> 7 data bits 1,0,0,0,0,0,1, two stop bits (8 cycles high) before next frame.
REQ-032 DEPTH=4, 5 back-to-back pushes while idle -> 1st pops at LOAD, 4 queued, 6th push dropped when ready=0; frames separated by exactly one high cycle.
REQ-033 Push 0x00 then assert rstn=0 during DATA -> tx=1 same cycle, level=0, line stays high after release.
REQ-034 Push on the same cycle STOP->LOAD pops with FIFO full -> push ignored, level goes DEPTH-1.

Source files
------------

// File: rtl/uart_tx_param_pkg.sv
// Shared definitions for the parameterised UART transmitter: FSM encoding,
// parity mode constants and the parity helper.
package uart_tx_param_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Narrow frames are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [7:0] d, input int mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_param_baud.sv
// Bit-period timer: while enabled, pulses tick for one cycle every BAUD_DIV
// cycles; clear restarts the period.
module uart_baud_tick #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with an inline write FIFO. Handshake: a word is accepted on
// any rising edge where start=1 and ready=1; start while ready=0 is dropped.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV  = 104,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [DATA_BITS-1:0]     data,
  output logic                     tx,
  output logic                     ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output state_t                   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 more;

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic                 baud_en;
  logic                 baud_clr;

  assign ready     = (level != FULL);
  assign push      = start && ready;
  assign pop       = (state == LOAD);
  assign busy      = (state != IDLE) || (level != '0);
  assign dbg_state = state;
  // A push landing on the decision edge counts, so a lone word leaves IDLE at once.
  assign more      = (level != '0) || push;
  assign baud_en   = (state == START) || (state == DATA) || (state == PAR) || (state == STOP);
  assign baud_clr  = (state == IDLE) || (state == LOAD);

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .enable (baud_en),
    .clear  (baud_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // tx is updated on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      par_bit <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (more) state <= LOAD;
        end
        LOAD: begin
          shift   <= mem[rd_ptr];
          par_bit <= parity_of(8'(mem[rd_ptr]), PARITY);
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            shift <= shift >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= more ? LOAD : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2)
// at BAUD_DIV=4 sharing one clock and reset.
module tb_uart_tx_param;
  import uart_tx_param_pkg::*;

  localparam int B = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] start_v;
  logic [7:0] data_v  [4];
  logic [3:0] tx_v;
  logic [3:0] ready_v;
  logic [3:0] busy_v;
  logic [2:0] level_v [4];
  state_t     st_v    [4];

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(B), .DEPTH(4)) u_8n1 (
    .clk(clk), .rstn(rstn), .start(start_v[0]), .data(data_v[0]), .tx(tx_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .level(level_v[0]), .dbg_state(st_v[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(B), .DEPTH(4)) u_8e1 (
    .clk(clk), .rstn(rstn), .start(start_v[1]), .data(data_v[1]), .tx(tx_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .level(level_v[1]), .dbg_state(st_v[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .BAUD_DIV(B), .DEPTH(4)) u_8o1 (
    .clk(clk), .rstn(rstn), .start(start_v[2]), .data(data_v[2]), .tx(tx_v[2]),
    .ready(ready_v[2]), .busy(busy_v[2]), .level(level_v[2]), .dbg_state(st_v[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(B), .DEPTH(4)) u_7n2 (
    .clk(clk), .rstn(rstn), .start(start_v[3]), .data(data_v[3][6:0]), .tx(tx_v[3]),
    .ready(ready_v[3]), .busy(busy_v[3]), .level(level_v[3]), .dbg_state(st_v[3]));

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // seq lists the frame in line order, leftmost bit first.
  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [15:0] seq;
    int         nbits;
  } vec_t;

  vec_t vecs [9];

  // ---------------- driver tasks ----------------
  task automatic send_vector(input int idx, input vec_t v);
    @(negedge clk);
    start_v[v.inst] = 1'b1;
    data_v[v.inst]  = v.data;
    @(negedge clk);
    start_v[v.inst] = 1'b0;
    chk($sformatf("v%0d_load_tx", idx), int'(tx_v[v.inst]), 1);
    chk($sformatf("v%0d_load_level", idx), int'(level_v[v.inst]), 1);
    chk($sformatf("v%0d_load_busy", idx), int'(busy_v[v.inst]), 1);
    for (int i = 0; i < v.nbits; i++) begin
      for (int c = 0; c < B; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d_bit%0d_c%0d", idx, i, c), int'(tx_v[v.inst]), int'(v.seq[v.nbits-1-i]));
      end
    end
    chk($sformatf("v%0d_busy_last_stop", idx), int'(busy_v[v.inst]), 1);
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), int'(busy_v[v.inst]), 0);
    chk($sformatf("v%0d_idle_tx", idx), int'(tx_v[v.inst]), 1);
    chk($sformatf("v%0d_idle_level", idx), int'(level_v[v.inst]), 0);
  endtask

  task automatic do_reset_check(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), int'(tx_v[i]), 1);
      chk($sformatf("%s_level%0d", tag, i), int'(level_v[i]), 0);
      chk($sformatf("%s_busy%0d", tag, i), int'(busy_v[i]), 0);
      chk($sformatf("%s_ready%0d", tag, i), int'(ready_v[i]), 1);
      chk($sformatf("%s_state%0d", tag, i), int'(st_v[i]), int'(IDLE));
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int j;
    int f;
    int o;
    int b;
    logic [7:0] fd;

    start_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;

    // reset state while rstn is held low
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), int'(tx_v[i]), 1);
      chk($sformatf("rst_ready%0d", i), int'(ready_v[i]), 1);
      chk($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
      chk($sformatf("rst_level%0d", i), int'(level_v[i]), 0);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- table-driven frames ----------------
    vecs[0] = '{0, 8'h55, 16'b0101010101,  10};
    vecs[1] = '{0, 8'h00, 16'b0000000001,  10};
    vecs[2] = '{0, 8'hFF, 16'b0111111111,  10};
    vecs[3] = '{1, 8'hA7, 16'b01110010111, 11};
    vecs[4] = '{2, 8'hA7, 16'b01110010101, 11};
    vecs[5] = '{1, 8'h00, 16'b00000000001, 11};
    vecs[6] = '{2, 8'hFF, 16'b01111111111, 11};
    vecs[7] = '{3, 8'h41, 16'b0100000111,  10};
    vecs[8] = '{3, 8'h2A, 16'b0010101011,  10};
    for (int k = 0; k < 9; k++) send_vector(k, vecs[k]);

    // ---------------- burst: 6 pushes on 8N1, sixth hits a full FIFO ----------------
    @(negedge clk);
    start_v[0] = 1'b1;
    data_v[0]  = 8'h01;
    for (int k = 1; k <= 5 * 41 + 3; k++) begin
      @(negedge clk);
      j = k - 1;
      if (j < 5 * 41) begin
        f  = j / 41;
        o  = j % 41;
        fd = 8'(f + 1);
        if (o == 0) e = 1;
        else begin
          b = (o - 1) / B;
          if (b == 0)      e = 0;
          else if (b <= 8) e = int'(fd[b-1]);
          else             e = 1;
        end
      end else begin
        e = 1;
        chk($sformatf("burst_busy_after_%0d", j), int'(busy_v[0]), 0);
      end
      chk($sformatf("burst_tx_%0d", j), int'(tx_v[0]), e);
      if (k <= 4) begin
        data_v[0] = 8'(k + 1);
      end else if (k == 5) begin
        chk("burst_full_ready", int'(ready_v[0]), 0);
        chk("burst_full_level", int'(level_v[0]), 4);
        data_v[0] = 8'h06;
      end else if (k == 6) begin
        start_v[0] = 1'b0;
        chk("burst_drop_level", int'(level_v[0]), 4);
      end
    end
    chk("burst_end_level", int'(level_v[0]), 0);

    // ---------------- push on the STOP->LOAD edge while full ----------------
    @(negedge clk);
    start_v[0] = 1'b1;
    data_v[0]  = 8'h11;
    for (int m = 1; m <= 43; m++) begin
      @(negedge clk);
      if (m <= 4) begin
        data_v[0] = 8'(8'h11 + m);
      end else if (m == 5) begin
        start_v[0] = 1'b0;
        chk("full_level_fill", int'(level_v[0]), 4);
      end else if (m == 40) begin
        chk("full_level_before", int'(level_v[0]), 4);
        chk("full_state_stop", int'(st_v[0]), int'(STOP));
      end else if (m == 41) begin
        start_v[0] = 1'b1;
        data_v[0]  = 8'h99;
      end else if (m == 42) begin
        start_v[0] = 1'b0;
        chk("full_load_state", int'(st_v[0]), int'(LOAD));
        chk("full_load_level", int'(level_v[0]), 4);
        chk("full_load_ready", int'(ready_v[0]), 0);
      end else if (m == 43) begin
        chk("full_after_pop_level", int'(level_v[0]), 3);
        chk("full_after_pop_tx", int'(tx_v[0]), 0);
      end
    end
    do_reset_check("rst_full");

    // ---------------- reset during DATA discards frame and queue ----------------
    @(negedge clk);
    start_v[0] = 1'b1;
    data_v[0]  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_state_data", int'(st_v[0]), int'(DATA));
    chk("mid_level", int'(level_v[0]), 1);
    chk("mid_tx", int'(tx_v[0]), 0);
    do_reset_check("rst_mid");
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_tx_%0d", k), int'(tx_v[0]), 1);
    end
    chk("post_rst_busy", int'(busy_v[0]), 0);
    chk("post_rst_level", int'(level_v[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
